// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_SUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte idle watchdog: cleared by every received byte, expires after
// TIMEOUT_CYCLES consecutive idle cycles while counting is enabled.
module loader_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Expire is raised on the idle cycle whose edge completes TIMEOUT_CYCLES idle cycles.
    assign expire = count && !load && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || load || !count)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses MAGIC/LEN/payload/SUM frames from the UART byte stream,
// packs payload into little-endian words for the instruction write port.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         INST_SIZE_IN_BYTE = 16384,
    parameter logic [7:0] MAGIC             = DEFAULT_MAGIC,
    parameter int         TIMEOUT_CYCLES    = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] inst_addr,
    output logic        inst_write_enable,
    output logic [3:0]  inst_write_width,
    output logic [31:0] inst_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    state_t      state;
    logic [31:0] len;
    logic [1:0]  len_idx;
    logic [31:0] byte_cnt;
    logic [31:0] word;
    logic [7:0]  sum;

    logic [31:0] len_full;
    logic [31:0] word_next;
    logic [1:0]  lane;
    logic        last_byte;
    logic        active;
    logic        expire;

    assign len_full  = {rx_data, len[31:8]};
    assign lane      = byte_cnt[1:0];
    assign last_byte = (byte_cnt == len - 32'd1);
    assign active    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_SUM);

    // Lane 0 restarts the word so upper lanes of a partial final word read as zero.
    always_comb begin
        word_next = word;
        if (lane == 2'd0)
            word_next = {24'd0, rx_data};
        else
            word_next[{lane, 3'b000} +: 8] = rx_data;
    end

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (rx_valid),
        .count (active),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            len               <= '0;
            len_idx           <= '0;
            byte_cnt          <= '0;
            word              <= '0;
            sum               <= '0;
            inst_addr         <= '0;
            inst_write_enable <= 1'b0;
            inst_write_width  <= '0;
            inst_write_data   <= '0;
            cpu_hold          <= 1'b1;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
        end else begin
            inst_write_enable <= 1'b0;
            if (rx_valid) begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_data == MAGIC) begin
                            state      <= S_LEN;
                            len        <= '0;
                            len_idx    <= '0;
                            byte_cnt   <= '0;
                            word       <= '0;
                            sum        <= '0;
                            inst_addr  <= '0;
                            cpu_hold   <= 1'b1;
                            load_done  <= 1'b0;
                            load_error <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        len     <= len_full;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'd3) begin
                            if (len_full > 32'(INST_SIZE_IN_BYTE)) begin
                                state      <= S_ERROR;
                                load_error <= 1'b1;
                            end else if (len_full == 32'd0) begin
                                state <= S_SUM;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        word     <= word_next;
                        sum      <= sum + rx_data;
                        byte_cnt <= byte_cnt + 32'd1;
                        if (lane == 2'd3 || last_byte) begin
                            inst_write_enable <= 1'b1;
                            inst_addr         <= {byte_cnt[31:2], 2'b00};
                            inst_write_width  <= 4'(lane) + 4'd1;
                            inst_write_data   <= word_next;
                        end
                        if (last_byte)
                            state <= S_SUM;
                    end
                    S_SUM: begin
                        if (rx_data == sum) begin
                            state     <= S_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (expire) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
            end
        end
    end

endmodule
